// File: rtl/mips_scoreboard_if.sv
// mips_scoreboard_if: issue-slot bundle between decode and the scoreboard.
// master = decode (drives the slot), slave = scoreboard (returns stall/fire).
interface mips_scoreboard_if #(
  parameter int AW = 5
);
  logic          issue_valid;
  logic [AW-1:0] issue_rs;
  logic [AW-1:0] issue_rt;
  logic          issue_use_rs;
  logic          issue_use_rt;
  logic          issue_wr_en;
  logic [AW-1:0] issue_rd;
  logic          flush;
  logic          clear;
  logic          stall;
  logic          issue_fire;

  modport master (
    output issue_valid, issue_rs, issue_rt,
    output issue_use_rs, issue_use_rt,
    output issue_wr_en, issue_rd,
    output flush, clear,
    input  stall, issue_fire
  );

  modport slave (
    input  issue_valid, issue_rs, issue_rt,
    input  issue_use_rs, issue_use_rt,
    input  issue_wr_en, issue_rd,
    input  flush, clear,
    output stall, issue_fire
  );
endinterface

// File: rtl/mips_scoreboard.sv
// mips_scoreboard: RAW/WAW interlock for the pipe_MIPS32 issue stage.
// Ports: clk, rst (sync, high); sb = issue slot (slave);
//   busy_mask = per-register pending write; stall_cycles = saturating stat.
module mips_scoreboard #(
  parameter int NREGS  = 32,
  parameter int AW     = 5,
  parameter int WB_LAT = 3,
  parameter int SCW    = 16
)(
  input  logic             clk,
  input  logic             rst,
  mips_scoreboard_if.slave sb,
  output logic [NREGS-1:0] busy_mask,
  output logic [SCW-1:0]   stall_cycles
);
  localparam int TW = $clog2(WB_LAT + 1);
  localparam int NX = 2 ** AW;

  logic [TW-1:0] timer [1:NREGS-1];
  logic [NX-1:0] busy_ext;
  logic          haz_rs;
  logic          haz_rt;
  logic          haz_rd;
  logic          hazard;
  logic          ld;

  always_comb begin
    busy_mask = '0;
    for (int i = 1; i < NREGS; i++)
      busy_mask[i] = (timer[i] != '0);
  end

  // Zero-extended so indices >= NREGS read as idle; bit 0 is always 0.
  assign busy_ext = NX'(busy_mask);

  assign haz_rs = sb.issue_use_rs & busy_ext[sb.issue_rs];
  assign haz_rt = sb.issue_use_rt & busy_ext[sb.issue_rt];
  assign haz_rd = sb.issue_wr_en  & busy_ext[sb.issue_rd];
  assign hazard = haz_rs | haz_rt | haz_rd;

  assign sb.stall =
    sb.issue_valid & ~sb.flush & ~rst & hazard;
  assign sb.issue_fire =
    sb.issue_valid & ~sb.flush & ~rst & ~hazard;

  assign ld = sb.issue_fire & sb.issue_wr_en
            & (sb.issue_rd != '0)
            & ({1'b0, sb.issue_rd} < (AW+1)'(NREGS));

  // WAW stall guarantees a loaded timer was already zero.
  always_ff @(posedge clk) begin
    if (rst || sb.clear) begin
      for (int i = 1; i < NREGS; i++)
        timer[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (ld && sb.issue_rd == AW'(i))
          timer[i] <= TW'(WB_LAT);
        else if (timer[i] != '0)
          timer[i] <= timer[i] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cycles <= '0;
    else if (sb.stall && stall_cycles != '1)
      stall_cycles <= stall_cycles + 1'b1;
  end
endmodule

// File: tb/tb_mips_scoreboard.sv
// tb_mips_scoreboard: directed checks of the issue-stage interlock.
// Main instance uses defaults; a second instance has SCW=4 for saturation.
module tb_mips_scoreboard;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] busy_m;
  logic [15:0] sc_m;
  logic [31:0] busy_s;
  logic [3:0]  sc_s;
  int          vectors = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  mips_scoreboard_if #(.AW(5)) m_if ();
  mips_scoreboard_if #(.AW(5)) s_if ();

  mips_scoreboard #(
    .NREGS(32), .AW(5), .WB_LAT(3), .SCW(16)
  ) dut (
    .clk(clk), .rst(rst), .sb(m_if),
    .busy_mask(busy_m), .stall_cycles(sc_m)
  );

  mips_scoreboard #(
    .NREGS(32), .AW(5), .WB_LAT(3), .SCW(4)
  ) dut_s (
    .clk(clk), .rst(rst), .sb(s_if),
    .busy_mask(busy_s), .stall_cycles(sc_s)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(
    input logic       v,
    input logic [4:0] rs,
    input logic [4:0] rt,
    input logic       urs,
    input logic       urt,
    input logic       we,
    input logic [4:0] rd
  );
    m_if.issue_valid  = v;
    m_if.issue_rs     = rs;
    m_if.issue_rt     = rt;
    m_if.issue_use_rs = urs;
    m_if.issue_use_rt = urt;
    m_if.issue_wr_en  = we;
    m_if.issue_rd     = rd;
  endtask

  task automatic idle();
    drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drv(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    for (int i = 0; i < 2; i++) begin
      #4;
      vectors++;
      if (m_if.stall !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_stall%0d: got %b want 0", i, m_if.stall);
      end
      vectors++;
      if (m_if.issue_fire !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_fire%0d: got %b want 0", i, m_if.issue_fire);
      end
      tick();
    end
    rst = 1'b0;
    idle();
    #4;
    vectors++;
    if (busy_m !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_busy: got %h want 0", busy_m);
    end
    vectors++;
    if (sc_m !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_sc: got %0d want 0", sc_m);
    end
    tick();
  endtask

  task automatic test_raw();
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1);
    #4;
    vectors++;
    if (m_if.issue_fire !== 1'b1) begin
      miscompares++;
      $display("FAIL raw_prod_fire: got %b want 1", m_if.issue_fire);
    end
    tick();
    drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd4);
    for (int i = 0; i < 3; i++) begin
      #4;
      vectors++;
      if (m_if.stall !== 1'b1 || m_if.issue_fire !== 1'b0) begin
        miscompares++;
        $display("FAIL raw_stall%0d: got stall=%b fire=%b want 1/0",
                 i, m_if.stall, m_if.issue_fire);
      end
      vectors++;
      if (busy_m !== 32'h2) begin
        miscompares++;
        $display("FAIL raw_busy%0d: got %h want 2", i, busy_m);
      end
      tick();
    end
    #4;
    vectors++;
    if (m_if.stall !== 1'b0 || m_if.issue_fire !== 1'b1) begin
      miscompares++;
      $display("FAIL raw_release: got stall=%b fire=%b want 0/1",
               m_if.stall, m_if.issue_fire);
    end
    tick();
    idle();
    #4;
    vectors++;
    if (sc_m !== 16'd3) begin
      miscompares++;
      $display("FAIL raw_sc: got %0d want 3", sc_m);
    end
    for (int i = 0; i < 3; i++) tick();
    vectors++;
    if (busy_m !== 32'h0) begin
      miscompares++;
      $display("FAIL raw_drain: got %h want 0", busy_m);
    end
  endtask

  task automatic test_independent();
    logic [31:0] exp_b [3];
    exp_b[0] = 32'hC;
    exp_b[1] = 32'h8;
    exp_b[2] = 32'h0;
    for (int i = 1; i <= 3; i++) begin
      drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'(i));
      #4;
      vectors++;
      if (m_if.stall !== 1'b0 || m_if.issue_fire !== 1'b1) begin
        miscompares++;
        $display("FAIL ind_fire%0d: got stall=%b fire=%b want 0/1",
                 i, m_if.stall, m_if.issue_fire);
      end
      tick();
    end
    idle();
    vectors++;
    if (busy_m !== 32'hE) begin
      miscompares++;
      $display("FAIL ind_busy: got %h want e", busy_m);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (busy_m !== exp_b[i]) begin
        miscompares++;
        $display("FAIL ind_clr%0d: got %h want %h", i, busy_m, exp_b[i]);
      end
    end
  endtask

  task automatic test_waw_r0();
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5);
    tick();
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd5);
    for (int i = 0; i < 3; i++) begin
      #4;
      vectors++;
      if (m_if.stall !== 1'b1) begin
        miscompares++;
        $display("FAIL waw_stall%0d: got %b want 1", i, m_if.stall);
      end
      tick();
    end
    #4;
    vectors++;
    if (m_if.issue_fire !== 1'b1) begin
      miscompares++;
      $display("FAIL waw_fire: got %b want 1", m_if.issue_fire);
    end
    tick();
    idle();
    for (int i = 0; i < 3; i++) tick();
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd0);
    tick();
    vectors++;
    if (busy_m !== 32'h0) begin
      miscompares++;
      $display("FAIL r0_busy: got %h want 0", busy_m);
    end
    drv(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0);
    #4;
    vectors++;
    if (m_if.stall !== 1'b0 || m_if.issue_fire !== 1'b1) begin
      miscompares++;
      $display("FAIL r0_src: got stall=%b fire=%b want 0/1",
               m_if.stall, m_if.issue_fire);
    end
    tick();
    idle();
    vectors++;
    if (sc_m !== 16'd6) begin
      miscompares++;
      $display("FAIL waw_sc: got %0d want 6", sc_m);
    end
  endtask

  task automatic test_flush_clear();
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1);
    tick();
    drv(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0);
    #4;
    vectors++;
    if (m_if.stall !== 1'b1) begin
      miscompares++;
      $display("FAIL fl_pre: got %b want 1", m_if.stall);
    end
    tick();
    m_if.flush = 1'b1;
    #4;
    vectors++;
    if (m_if.stall !== 1'b0 || m_if.issue_fire !== 1'b0) begin
      miscompares++;
      $display("FAIL fl_sup: got stall=%b fire=%b want 0/0",
               m_if.stall, m_if.issue_fire);
    end
    tick();
    m_if.flush = 1'b0;
    #4;
    vectors++;
    if (m_if.stall !== 1'b1 || busy_m !== 32'h2) begin
      miscompares++;
      $display("FAIL fl_post: got stall=%b busy=%h want 1/2",
               m_if.stall, busy_m);
    end
    tick();
    #4;
    vectors++;
    if (m_if.issue_fire !== 1'b1) begin
      miscompares++;
      $display("FAIL fl_fire: got %b want 1", m_if.issue_fire);
    end
    tick();
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd1);
    tick();
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd2);
    tick();
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd3);
    m_if.clear = 1'b1;
    #4;
    vectors++;
    if (busy_m !== 32'h6 || m_if.issue_fire !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_pre: got busy=%h fire=%b want 6/1",
               busy_m, m_if.issue_fire);
    end
    tick();
    m_if.clear = 1'b0;
    drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0);
    #4;
    vectors++;
    if (busy_m !== 32'h0) begin
      miscompares++;
      $display("FAIL clr_busy: got %h want 0", busy_m);
    end
    vectors++;
    if (m_if.stall !== 1'b0 || m_if.issue_fire !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_dep: got stall=%b fire=%b want 0/1",
               m_if.stall, m_if.issue_fire);
    end
    tick();
    idle();
    vectors++;
    if (sc_m !== 16'd8) begin
      miscompares++;
      $display("FAIL fl_sc: got %0d want 8", sc_m);
    end
  endtask

  task automatic test_reset_mid();
    drv(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd7);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (busy_m !== 32'h0 || sc_m !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_mid: got busy=%h sc=%0d want 0/0", busy_m, sc_m);
    end
  endtask

  task automatic test_saturation();
    s_if.issue_valid  = 1'b1;
    s_if.issue_rs     = 5'd1;
    s_if.issue_use_rs = 1'b1;
    s_if.issue_wr_en  = 1'b1;
    s_if.issue_rd     = 5'd1;
    for (int i = 0; i < 8; i++) tick();
    vectors++;
    if (sc_s !== 4'd6) begin
      miscompares++;
      $display("FAIL sat_mid: got %0d want 6", sc_s);
    end
    for (int i = 0; i < 32; i++) tick();
    vectors++;
    if (sc_s !== 4'd15) begin
      miscompares++;
      $display("FAIL sat_end: got %0d want 15", sc_s);
    end
    s_if.issue_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    m_if.flush = 1'b0;
    m_if.clear = 1'b0;
    s_if.issue_valid  = 1'b0;
    s_if.issue_rs     = 5'd0;
    s_if.issue_rt     = 5'd0;
    s_if.issue_use_rs = 1'b0;
    s_if.issue_use_rt = 1'b0;
    s_if.issue_wr_en  = 1'b0;
    s_if.issue_rd     = 5'd0;
    s_if.flush        = 1'b0;
    s_if.clear        = 1'b0;
    tick();
    test_reset();
    test_raw();
    test_independent();
    test_waw_r0();
    test_flush_clear();
    test_reset_mid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mips_scoreboard.md
Name: mips_scoreboard

Overview:
- Parametrised register-hazard interlock for the pipe_MIPS32 issue stage.
- Removes the need for dummy OR instructions between dependent instructions.
- Tracks in-flight destination registers with per-register countdown timers.
- Stalls issue on RAW and WAW hazards, and counts stall cycles for performance debug.

Parameters:
NREGS, 32, number of architectural registers; register 0 is hard-wired zero and never busy
AW, 5, register-index width; must satisfy 2**AW >= NREGS
WB_LAT, 3, cycles from issue to write-back result becoming readable; legal range 1..15
SCW, 16, width of the stall-cycle statistics counter

Ports:
clk  in  1  single system clock; all state updates on rising edge
rst  in  1  synchronous active-high reset
issue_valid  in  1  decode stage presents an instruction this cycle
issue_rs  in  AW  first source register index
issue_rt  in  AW  second source register index
issue_use_rs  in  1  instruction reads rs
issue_use_rt  in  1  instruction reads rt
issue_wr_en  in  1  instruction writes a register
issue_rd  in  AW  destination register index
flush  in  1  squash the current issue slot (taken branch); in-flight timers keep running
clear  in  1  zero all timers (HALT/restart)
stall  out  1  hold PC and IF/ID this cycle
issue_fire  out  1  instruction accepted into the pipeline this cycle
busy_mask  out  NREGS  bit i = register i has a pending write
stall_cycles  out  SCW  saturating count of cycles with stall=1

Behaviour:
- State: one timer per register, width ceil(log2(WB_LAT+1)). busy[i] = (timer[i] != 0). busy[0] is constant 0 and timer[0] is never written.
- Reset (rst=1 at an edge): all timers = 0, stall_cycles = 0.
  - stall and issue_fire are forced to 0 while rst=1.
  - busy_mask reads 0 the cycle after reset.
  - Reset mid-operation abandons all pending writes.
- stall (combinational) = issue_valid & ~flush & ~rst & hazard, where hazard is any of:
  - RAW on rs: issue_use_rs & busy[issue_rs]
  - RAW on rt: issue_use_rt & busy[issue_rt]
  - WAW on rd: issue_wr_en & busy[issue_rd]
- Hazard index rules:
  - Index 0 never causes a hazard.
  - Indices >= NREGS are treated as not busy.
- issue_fire = issue_valid & ~flush & ~rst & ~hazard. flush suppresses both stall and fire.
- Timer update each edge (rst=0, clear=0):
  - Every nonzero timer decrements by 1.
  - If issue_fire & issue_wr_en & issue_rd != 0 & issue_rd < NREGS: timer[issue_rd] <= WB_LAT. The load overrides the decrement. No conflict is possible, because WAW stall guarantees the timer was 0.
- clear=1: all timers <= 0 at that edge, regardless of a simultaneous fire; issue_fire is still reported.
- Latency: a producer firing at edge N makes a dependent issuable at the cycle following edge N+WB_LAT. With WB_LAT=3, a back-to-back dependent stalls exactly 3 cycles.
- stall_cycles: increments by 1 on each edge where stall=1, and saturates at 2**SCW-1 (no wrap).
- Source and destination equal (e.g. ADD R1,R1,R1): the hazard is checked against the old state only, so the instruction fires if R1 is idle.
- No internal state machine beyond the timers. The block is fully pipelined and accepts one instruction per cycle when hazard-free.

Test Plan:
- Reset: assert rst for 2 cycles with issue_valid=1, rs=1, use_rs=1 -> stall=0, issue_fire=0; after release busy_mask=0, stall_cycles=0.
- Back-to-back RAW (WB_LAT=3): fire ADDI R1 (rd=1), next cycle ADD R4,R1,R2 -> stall=1 for 3 cycles, then issue_fire=1; stall_cycles=3; busy_mask=0x2 during the stall.
- Independent stream: ADDI R1, ADDI R2, ADDI R3 on consecutive cycles -> no stall; busy_mask=0xE after the third edge; each bit clears 3 cycles after its set.
- WAW plus R0: fire rd=5, then an instruction with rd=5 and no sources -> stalls 3 cycles. A write to rd=0 never sets busy; a source rs=0 never stalls.
- Flush/clear: during a stall assert flush -> stall=0, issue_fire=0, timers still decrement. Assert clear with R1 and R2 busy -> busy_mask=0 next cycle; a dependent fires immediately.
- Saturation (SCW=4): hold a permanent RAW by re-issuing the producer so the timer reloads, stalling more than 15 cycles -> stall_cycles stops at 15.
